sad_decision: RTL and testbench
===============================

SAD_DECISION -- requirements
Module: sad_decision

Interface
REQ-001 Parameter BLOCK_ROWS, default 8, number of compute_sad rows accumulated per block; legal range 1..64.
REQ-002 Parameter ACC_W, default 16, width of each per-position accumulator and of best_sad.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port sad_in  input  65  five 13-bit row SADs: [12:0] right quarter (pos 0), [25:13] right half (pos 1), [38:26] full pixel (pos 2), [51:39] left half (pos 3), [64:52] left quarter (pos 4).
REQ-006 Port sad_valid  input  1  sad_in carries one row.
REQ-007 Port sad_ready  output  1  block accepts a row this cycle.
REQ-008 Port flush  input  1  synchronous abort of the current block.
REQ-009 Port result_valid  output  1  best_pos/best_sad hold a completed decision.
REQ-010 Port result_ready  input  1  downstream consumes the result.
REQ-011 Port best_pos  output  3  winning position index 0..4 per REQ-005.
REQ-012 Port best_sad  output  ACC_W  accumulated SAD of the winning position.

Function
REQ-013 FSM states: ACCUM, COMPARE, DONE; reset state ACCUM.
REQ-014 sad_ready is 1 only in ACCUM; a row is accepted when sad_valid and sad_ready are both 1 at a rising edge.
REQ-015 On acceptance, each of the five accumulators adds its zero-extended 13-bit lane; the row counter increments.
REQ-016 Acceptance of row BLOCK_ROWS moves the FSM to COMPARE and clears the row counter.
REQ-017 COMPARE lasts exactly 5 cycles and examines one accumulator per cycle in the order 2, 1, 3, 0, 4; the first examined value seeds the best value, and later values replace it only if strictly less.
REQ-018 Ties therefore resolve to full pixel, then right half, left half, right quarter, left quarter.
REQ-019 After the fifth COMPARE cycle the FSM enters DONE; result_valid rises exactly 5 edges after the edge that accepted the final row.
REQ-020 In DONE, result_valid, best_pos and best_sad stay stable until result_ready is 1 at an edge; that edge clears all accumulators and returns to ACCUM.
REQ-021 result_valid is 0 in ACCUM and COMPARE.
REQ-022 flush=1 at an edge, in any state, clears accumulators and row counter, drops any simultaneous row or pending result, and returns to ACCUM; flush has priority over every other event.
REQ-023 sad_valid while sad_ready=0 is ignored; the upstream holds data.

Reset
REQ-024 rst_n low asynchronously forces state ACCUM, accumulators 0, row counter 0, result_valid 0, best_pos 0, best_sad 0; sad_ready is 1 after reset.
REQ-025 Reset mid-block discards all partial accumulation; the first row accepted after release is row 1.

Configuration
REQ-026 With macro SAD_SATURATE_EN defined, each accumulator clamps to 2^ACC_W-1 instead of exceeding it.
REQ-027 Without SAD_SATURATE_EN, accumulators wrap modulo 2^ACC_W.

Verification
REQ-028 Bench covers these scenarios.
- Scenario 1: 8 rows, each with lanes {pos0..pos4} = {40, 30, 20, 35, 50}. Required: result_valid 5 edges after row 8, best_pos 2, best_sad 160.
- Scenario 2: all lanes equal to 100 for 8 rows. Required: best_pos 2, best_sad 800.
- Scenario 3: lanes {10, 50, 50, 50, 10} for 8 rows. Required: best_pos 0 (tie with 4), best_sad 80.
- Scenario 4: flush asserted with sad_valid on row 5, then 8 rows of {9, 9, 9, 9, 1}. Required: best_pos 4, best_sad 8; no result from the aborted block.
- Scenario 5: result_ready held 0 for 10 cycles in DONE. Required: outputs stable and sad_ready 0 throughout; ACCUM resumes after the handshake edge.
- Scenario 6: BLOCK_ROWS=64, ACC_W=16, lane 2 = 8191 on every row, others 8191. With SAD_SATURATE_EN: best_sad 65535. Without it: best_sad 524224 mod 65536 = 65472.

Source files
------------

// File: rtl/sad_decision.sv
// Sub-pel decision: accumulates five per-position row SADs over a block and picks the minimum.
// Optional macro SAD_SATURATE_EN clamps accumulators at 2^ACC_W-1 instead of wrapping.

module sad_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [12:0]      i_lane,
    output logic [ACC_W-1:0] o_acc
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_next;

`ifdef SAD_SATURATE_EN
    logic [ACC_W:0] w_sum;
    always_comb begin
        w_sum  = {1'b0, r_acc} + (ACC_W+1)'(i_lane);
        w_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    end
`else
    always_comb w_next = r_acc + ACC_W'(i_lane);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_acc <= '0;
        else if (i_clr)  r_acc <= '0;
        else if (i_add)  r_acc <= w_next;
    end

    assign o_acc = r_acc;
endmodule

module sad_decision #(
    parameter int BLOCK_ROWS = 8,
    parameter int ACC_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [64:0]      sad_in,
    input  logic             sad_valid,
    output logic             sad_ready,
    input  logic             flush,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [2:0]       best_pos,
    output logic [ACC_W-1:0] best_sad
);
    localparam int NUM_POS = 5;
    localparam int CNT_W   = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

    typedef enum logic [1:0] {ACCUM, COMPARE, DONE} state_t;

    state_t                          r_state, w_next_state;
    logic [CNT_W-1:0]                r_row;
    logic [2:0]                      r_cmp;
    logic [2:0]                      r_best_pos;
    logic [ACC_W-1:0]                r_best_sad;
    logic [NUM_POS-1:0][ACC_W-1:0]   w_acc;
    logic [2:0]                      w_cand_pos;
    logic [ACC_W-1:0]                w_cand;
    logic                            w_accept, w_last, w_clr;

    assign w_accept = sad_valid && sad_ready && !flush;
    assign w_last   = w_accept && (r_row == CNT_W'(BLOCK_ROWS - 1));
    assign w_clr    = flush || (r_state == DONE && result_ready);

    for (genvar g = 0; g < NUM_POS; g++) begin : g_pos
        sad_acc #(.ACC_W(ACC_W)) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (w_clr),
            .i_add  (w_accept),
            .i_lane (sad_in[13*g +: 13]),
            .o_acc  (w_acc[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_last) w_next_state = COMPARE;
                COMPARE: if (r_cmp == 3'd4) w_next_state = DONE;
                DONE:    if (result_ready) w_next_state = ACCUM;
                default: w_next_state = ACCUM;
            endcase
        end
    end

    always_comb begin
        sad_ready    = (r_state == ACCUM);
        result_valid = (r_state == DONE);
        best_pos     = r_best_pos;
        best_sad     = r_best_sad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_row <= '0;
        else if (flush || w_last)   r_row <= '0;
        else if (w_accept)          r_row <= r_row + 1'b1;
    end

    // Examination order doubles as the tie-break priority: full, right half, left half, right qtr, left qtr.
    always_comb begin
        case (r_cmp)
            3'd0:    w_cand_pos = 3'd2;
            3'd1:    w_cand_pos = 3'd1;
            3'd2:    w_cand_pos = 3'd3;
            3'd3:    w_cand_pos = 3'd0;
            default: w_cand_pos = 3'd4;
        endcase
        w_cand = w_acc[w_cand_pos];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp      <= '0;
            r_best_pos <= '0;
            r_best_sad <= '0;
        end else if (flush) begin
            r_cmp <= '0;
        end else if (r_state == COMPARE) begin
            r_cmp <= (r_cmp == 3'd4) ? 3'd0 : r_cmp + 3'd1;
            if (r_cmp == 3'd0 || w_cand < r_best_sad) begin
                r_best_pos <= w_cand_pos;
                r_best_sad <= w_cand;
            end
        end
    end
endmodule

// File: tb/tb_sad_decision.sv
// Scoreboarded bench for sad_decision: an 8-row instance for the main scenarios and a 64-row
// instance for the accumulator overflow case; the reference model follows SAD_SATURATE_EN.

module tb_sad_decision;
`ifdef SAD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint AMAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sv   [2];
    logic [64:0] sin  [2];
    logic        fl   [2];
    logic        rr   [2];
    logic        srdy [2];
    logic        rv   [2];
    logic [2:0]  bp   [2];
    logic [15:0] bs   [2];

    int errs = 0, checks = 0, cyc = 0;
    int lim [2] = '{8, 64};

    typedef struct {int inst; int pos; longint sad; int cyc;} exp_t;
    exp_t   q[$];
    longint sums [2][5];
    int     rows [2];
    logic   prv_v [2], prv_hs [2];
    logic [2:0]  prv_bp [2];
    logic [15:0] prv_bs [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sad_decision #(.BLOCK_ROWS(8), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sad_in(sin[0]), .sad_valid(sv[0]), .sad_ready(srdy[0]),
        .flush(fl[0]), .result_valid(rv[0]), .result_ready(rr[0]), .best_pos(bp[0]), .best_sad(bs[0]));

    sad_decision #(.BLOCK_ROWS(64), .ACC_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .sad_in(sin[1]), .sad_valid(sv[1]), .sad_ready(srdy[1]),
        .flush(fl[1]), .result_valid(rv[1]), .result_ready(rr[1]), .best_pos(bp[1]), .best_sad(bs[1]));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pending(input int k);
        int n = 0;
        foreach (q[i]) if (q[i].inst == k) n++;
        return n;
    endfunction

    function automatic void purge(input int k);
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].inst == k) q.delete(i);
    endfunction

    function automatic void clear_model(input int k);
        for (int p = 0; p < 5; p++) sums[k][p] = 0;
        rows[k] = 0;
    endfunction

    // Reference: per-position totals, then min over positions with priority 2,1,3,0,4.
    function automatic void push_expected(input int k, input int acc_cyc);
        int     ord [5] = '{2, 1, 3, 0, 4};
        exp_t   e;
        longint v;
        e.inst = k; e.cyc = acc_cyc; e.pos = -1; e.sad = 0;
        foreach (ord[i]) begin
            v = SAT ? ((sums[k][ord[i]] > AMAX) ? AMAX : sums[k][ord[i]]) : (sums[k][ord[i]] % (AMAX + 1));
            if (e.pos < 0 || v < e.sad) begin
                e.pos = ord[i];
                e.sad = v;
            end
        end
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                clear_model(k);
                purge(k);
                prv_v[k] = 1'b0; prv_hs[k] = 1'b0;
            end else begin
                if (rv[k] && !prv_v[k]) begin
                    int idx = -1;
                    foreach (q[i]) if (idx < 0 && q[i].inst == k) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_result[%0d]", k), 1, 0);
                    end else begin
                        chk($sformatf("best_pos[%0d]", k), bp[k], q[idx].pos);
                        chk($sformatf("best_sad[%0d]", k), bs[k], q[idx].sad);
                        chk($sformatf("latency[%0d]", k), cyc - q[idx].cyc, 5);
                        q.delete(idx);
                    end
                end
                if (rv[k] && prv_v[k] && !prv_hs[k]) begin
                    chk($sformatf("hold_pos[%0d]", k), bp[k], prv_bp[k]);
                    chk($sformatf("hold_sad[%0d]", k), bs[k], prv_bs[k]);
                end
                if (rv[k]) chk($sformatf("ready_in_done[%0d]", k), srdy[k], 0);
                if (prv_hs[k]) begin
                    chk($sformatf("ready_after_hs[%0d]", k), srdy[k], 1);
                    chk($sformatf("valid_after_hs[%0d]", k), rv[k], 0);
                end
                if (fl[k]) begin
                    clear_model(k);
                    if (!rv[k]) purge(k);
                end else if (sv[k] && srdy[k]) begin
                    for (int p = 0; p < 5; p++) sums[k][p] += longint'(sin[k][13*p +: 13]);
                    rows[k]++;
                    if (rows[k] == lim[k]) begin
                        push_expected(k, cyc + 1);
                        clear_model(k);
                    end
                end
                prv_hs[k] = rv[k] && (rr[k] || fl[k]);
                prv_v[k]  = rv[k];
                prv_bp[k] = bp[k];
                prv_bs[k] = bs[k];
            end
        end
    end

    function automatic logic [64:0] pack(input int l0, l1, l2, l3, l4);
        return {13'(l4), 13'(l3), 13'(l2), 13'(l1), 13'(l0)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_row(input int k, input logic [64:0] d);
        int n = 0;
        sin[k] = d;
        sv[k]  = 1'b1;
        forever begin
            @(negedge clk);
            if (srdy[k]) break;
            n++;
            if (n > 200) begin chk("row_accept_timeout", 0, 1); break; end
        end
        tick(1);
        sv[k] = 1'b0;
    endtask

    task automatic send_block(input int k, input int n, input logic [64:0] d);
        for (int r = 0; r < n; r++) send_row(k, d);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        forever begin
            @(negedge clk);
            if (pending(k) == 0 && !rv[k]) break;
            n++;
            if (n > 400) begin chk("drain_timeout", pending(k), 0); break; end
        end
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            sv[k] = 0; fl[k] = 0; rr[k] = 1; sin[k] = '0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready[%0d]", k), srdy[k], 1);
            chk($sformatf("rst_valid[%0d]", k), rv[k], 0);
            chk($sformatf("rst_pos[%0d]", k), bp[k], 0);
            chk($sformatf("rst_sad[%0d]", k), bs[k], 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Scenario 1: distinct lanes, full pixel wins
        send_block(0, 8, pack(40, 30, 20, 35, 50));
        wait_idle(0);

        // Reset mid-block: partial rows must be forgotten
        send_block(0, 3, pack(1, 2, 3, 4, 5));
        rst_n = 1'b0;
        #1 chk("midrst_valid", rv[0], 0);
        chk("midrst_ready", srdy[0], 1);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Scenario 2: all equal -> full pixel
        send_block(0, 8, pack(100, 100, 100, 100, 100));
        wait_idle(0);

        // Scenario 3: tie between pos 0 and 4 resolves to 0
        send_block(0, 8, pack(10, 50, 50, 50, 10));
        wait_idle(0);

        // Scenario 4: flush together with row 5
        send_block(0, 4, pack(1, 1, 1, 1, 1));
        sin[0] = pack(1, 1, 1, 1, 1);
        sv[0] = 1'b1; fl[0] = 1'b1;
        tick(1);
        sv[0] = 1'b0; fl[0] = 1'b0;
        send_block(0, 8, pack(9, 9, 9, 9, 1));
        wait_idle(0);

        // Scenario 5: result held for 10 cycles before the handshake
        rr[0] = 1'b0;
        send_block(0, 8, pack(7, 3, 5, 3, 9));
        begin
            int n = 0;
            forever begin
                @(negedge clk);
                if (rv[0]) break;
                n++;
                if (n > 50) begin chk("result_timeout", 0, 1); break; end
            end
        end
        tick(10);
        rr[0] = 1'b1;
        wait_idle(0);

        // Flush while in COMPARE drops the result
        send_block(0, 8, pack(2, 2, 2, 2, 2));
        tick(2);
        fl[0] = 1'b1;
        tick(1);
        fl[0] = 1'b0;
        tick(8);
        chk("flushed_compare_valid", rv[0], 0);

        // Randomised blocks with gaps, ties, late handshakes and a mid-block flush
        for (int b = 0; b < 12; b++) begin
            int cut = (b == 5) ? int'($urandom_range(1, 7)) : 0;
            for (int r = 0; r < 8 + cut; r++) begin
                logic [64:0] d;
                if (b % 2 == 0)
                    d = pack($urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191),
                             $urandom_range(0, 8191), $urandom_range(0, 8191));
                else
                    d = pack($urandom_range(100, 101), $urandom_range(100, 101), $urandom_range(100, 101),
                             $urandom_range(100, 101), $urandom_range(100, 101));
                if (cut != 0 && r == cut) begin
                    fl[0] = 1'b1; tick(1); fl[0] = 1'b0;
                end
                rr[0] = ($urandom_range(0, 3) != 0);
                send_row(0, d);
                tick($urandom_range(0, 2));
            end
            rr[0] = 1'b0;
            tick($urandom_range(4, 9));
            rr[0] = 1'b1;
            wait_idle(0);
        end

        // Scenario 6: 64 rows of 8191 overflow 16 bits
        send_block(1, 64, pack(8191, 8191, 8191, 8191, 8191));
        wait_idle(1);

        chk("leftover[0]", pending(0), 0);
        chk("leftover[1]", pending(1), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
